// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache with its miss-handling FSM.
// Lookup is combinational in COMPARE. A miss runs an optional 4-beat dirty
// write-back and then a 4-beat fill. After that the held cpu request hits.
module cache_controller #(
  parameter int ADDR_W  = 10,
  parameter int TAG_W   = 4,
  parameter int INDEX_W = 2,
  parameter int WORD_W  = 2,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Write_Data,
  output logic [DATA_W-1:0] rData,
  output logic              hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  access_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << WORD_W;

  typedef enum logic [1:0] {S_COMPARE, S_WRITEBACK, S_FILL} state_t;

  state_t                          state_q, state_d;
  logic [WORD_W-1:0]               beat_q, beat_d;
  logic [SETS-1:0]                 valid_q, valid_d;
  logic [SETS-1:0]                 dirty_q, dirty_d;
  logic [SETS-1:0][TAG_W-1:0]      tag_q, tag_d;
  logic [TAG_W-1:0]                lat_tag_q, lat_tag_d;
  logic [INDEX_W-1:0]              lat_idx_q, lat_idx_d;
  logic [CNT_W-1:0]                acc_q, acc_d;
  logic [CNT_W-1:0]                miss_q, miss_d;

  // Data array has no reset; contents are only trusted behind valid.
  logic [DATA_W-1:0]               data_q [SETS][WORDS];
  logic                            dat_we;
  logic [INDEX_W-1:0]              dat_idx;
  logic [WORD_W-1:0]               dat_word;
  logic [DATA_W-1:0]               dat_wdata;

  // Address fields; byte offset bits are not used by a word cache.
  logic [TAG_W-1:0]   a_tag;
  logic [INDEX_W-1:0] a_idx;
  logic [WORD_W-1:0]  a_word;
  logic               req;
  logic               match;
  logic               unused_byte;

  assign a_tag       = Address[ADDR_W-1 -: TAG_W];
  assign a_idx       = Address[2+WORD_W +: INDEX_W];
  assign a_word      = Address[2 +: WORD_W];
  assign unused_byte = ^Address[1:0];
  assign req         = read | write;
  assign match       = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

  assign access_count = acc_q;
  assign miss_count   = miss_q;

  // State, tag store and statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_COMPARE;
      beat_q    <= '0;
      valid_q   <= '0;
      dirty_q   <= '0;
      tag_q     <= '0;
      lat_tag_q <= '0;
      lat_idx_q <= '0;
      acc_q     <= '0;
      miss_q    <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      valid_q   <= valid_d;
      dirty_q   <= dirty_d;
      tag_q     <= tag_d;
      lat_tag_q <= lat_tag_d;
      lat_idx_q <= lat_idx_d;
      acc_q     <= acc_d;
      miss_q    <= miss_d;
    end
  end

  // Data array write port: cpu write hit or fill beat.
  always_ff @(posedge clock) begin
    if (dat_we) data_q[dat_idx][dat_word] <= dat_wdata;
  end

  // Next-state, tag-store update and output decode.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    valid_d   = valid_q;
    dirty_d   = dirty_q;
    tag_d     = tag_q;
    lat_tag_d = lat_tag_q;
    lat_idx_d = lat_idx_q;
    acc_d     = acc_q;
    miss_d    = miss_q;
    hit       = 1'b0;
    rData     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    dat_we    = 1'b0;
    dat_idx   = a_idx;
    dat_word  = a_word;
    dat_wdata = Write_Data;

    case (state_q)
      S_COMPARE: begin
        if (req) begin
          if (match) begin
            hit   = 1'b1;
            acc_d = (acc_q == {CNT_W{1'b1}}) ? acc_q : acc_q + CNT_W'(1);
            if (write) begin
              // read&write together is a write; rData stays 0
              dat_we         = 1'b1;
              dirty_d[a_idx] = 1'b1;
            end else begin
              rData = data_q[a_idx][a_word];
            end
          end else begin
            miss_d    = (miss_q == {CNT_W{1'b1}}) ? miss_q : miss_q + CNT_W'(1);
            lat_tag_d = a_tag;
            lat_idx_d = a_idx;
            state_d   = (valid_q[a_idx] && dirty_q[a_idx]) ? S_WRITEBACK : S_FILL;
          end
        end
      end

      S_WRITEBACK: begin
        // tag_q still holds the victim's tag until the fill completes
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[lat_idx_q], lat_idx_q, beat_q, 2'b00};
        mem_wdata = data_q[lat_idx_q][beat_q];
        if (mem_ready) begin
          beat_d = beat_q + WORD_W'(1);
          if (beat_q == {WORD_W{1'b1}}) begin
            dirty_d[lat_idx_q] = 1'b0;
            state_d            = S_FILL;
          end
        end
      end

      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {lat_tag_q, lat_idx_q, beat_q, 2'b00};
        if (mem_ready) begin
          dat_we    = 1'b1;
          dat_idx   = lat_idx_q;
          dat_word  = beat_q;
          dat_wdata = mem_rdata;
          beat_d    = beat_q + WORD_W'(1);
          if (beat_q == {WORD_W{1'b1}}) begin
            tag_d[lat_idx_q]   = lat_tag_q;
            valid_d[lat_idx_q] = 1'b1;
            dirty_d[lat_idx_q] = 1'b0;
            state_d            = S_COMPARE;
          end
        end
      end

      default: state_d = S_COMPARE;
    endcase
  end

endmodule
